gpa_fhdo_spi_ctrl: RTL and testbench
====================================

# gpa_fhdo_spi_ctrl

Parametrised successor SPI controller between the gradient BRAM core and the GPA-FHDO DAC board. It accepts 32-bit command words through a valid/ready handshake and serialises one or more DAC frames per command. It supports any channel count up to 8, wider frames, broadcast expansion in hardware and raw register frames. It sends the DAC sync-register setup once after reset rather than before every write, and can optionally capture SDI readback.

## Interface
- NUM_CH, 4: DAC channels, 1..8.
- FRAME_BITS, 24: SPI frame length, 24..32; frame left-padded with zeros above bit 19.
- DIV_W, 6: width of divider input.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- data_i  in  32  command: [15:0] payload, [18:16] channel, [24] broadcast, [25] raw (send data_i[FRAME_BITS-1:0] verbatim).
- valid_i  in  1  command valid.
- ready_o  out  1  high in IDLE only; transfer on valid_i && ready_o.
- spi_clk_div_i  in  DIV_W  half-bit period minus one, sampled at accept.
- fhd_clk_o  out  1  SCLK, idles high.
- fhd_sdo_o  out  1  MOSI, MSB first.
- fhd_csn_o  out  1  chip select, active low.
- fhd_sdi_i  in  1  MISO (readback only).
- busy_o  out  1  equals !ready_o.
- err_o  out  1  one-cycle pulse: non-broadcast, non-raw command with channel >= NUM_CH.
- rdata_o  out  FRAME_BITS  last captured SDI frame.
- rdata_valid_o  out  1  one-cycle pulse when rdata_o updates.

## Operation
- Reset values: ready_o 1, busy_o 0, fhd_clk_o 1, fhd_csn_o 1, fhd_sdo_o 0, err_o 0, rdata_o 0, rdata_valid_o 0, init_done 0. State is IDLE.
- Frame for channel c is the value (1<<19)|(c<<16)|payload. The sync frame is (2<<16)|0x0000.
- States and transitions:
  - IDLE: on accept, latch data_i and the divider. If the command is invalid (bad channel), pulse err_o and stay in IDLE. Otherwise go to LOAD.
  - LOAD: select the next frame. If !init_done, select the sync frame. Otherwise select the raw word, or the frame for the current channel.
  - SHIFT: drive FRAME_BITS bits.
  - GAP: hold CS high for the minimum inter-frame gap.
  - After GAP:
    - if the sync frame was just sent, set init_done and return to LOAD;
    - if in broadcast and the channel is below NUM_CH-1, increment the channel and return to LOAD;
    - otherwise go to IDLE.
- Broadcast sends the payload to channels 0..NUM_CH-1 in order, NUM_CH frames. The raw bit overrides broadcast.
- valid_i while busy is ignored; there is no queue. Changes to spi_clk_div_i during a command have no effect.
- Reset mid-transfer aborts the current frame. Outputs return to their reset values on the next edge, and the sync frame is resent before the next command.

## Timing
- H = spi_clk_div+1 clk cycles (half-bit). Bit time is 2H.
- Accept at edge 0. fhd_csn_o goes low and LOAD begins at edge 1, i.e. one cycle of latency. CS-to-first-bit setup is H.
- Per bit:
  - fhd_sdo_o updates while fhd_clk_o rises to high;
  - after H, fhd_clk_o falls, and the DAC samples on this edge;
  - SDI is sampled on the same clk edge the fall is driven;
  - after another H, the next bit starts.
- After the last falling edge, fhd_clk_o returns high H later, and fhd_csn_o rises at that same edge.
- GAP holds CS high for 2H cycles.
- Frame cost is H (setup) + 2H·FRAME_BITS + 2H (gap).
- ready_o rises on the cycle after GAP ends for the final frame.
- err_o pulses at edge 1. ready_o stays 1 throughout.

## Configuration
- GPA_FHDO_READBACK_EN defined:
  - a FRAME_BITS shift register captures fhd_sdi_i MSB first at each falling edge;
  - at CS rise, rdata_o is loaded and rdata_valid_o pulses for 1 cycle;
  - each frame pulses, including the sync frame and every broadcast frame.
- Undefined: rdata_o is held 0, rdata_valid_o is held 0, fhd_sdi_i is unused, and there is no capture logic.

## Test plan
- Reset, then send data_i=0x0001_ABCD with div=1:
  - a sync frame 0x020000 is sent first, then 0x09ABCD;
  - each frame is 2+96+4 cycles and MSB-first bits match;
  - ready_o returns 1.
- Second command 0x0000_1234 after init: a single frame 0x081234 is sent, with no sync frame.
- Broadcast 0x0100_8000 with NUM_CH=4: frames 0x088000, 0x098000, 0x0A8000 and 0x0B8000 are sent in order, each separated by a CS-high gap of 4 cycles at div=1.
- Channel 5 with NUM_CH=4: err_o pulses 1 cycle, and CS and SCLK stay idle. Asserting valid_i during busy has no effect, and the frame count is unchanged.
- Assert rst at bit 10 of a frame: the next cycle shows CS=1, SCLK=1 and SDO=0. The next command resends 0x020000.
- GPA_FHDO_READBACK_EN with SDI driven from a 0xA5A5A5 pattern: rdata_o equals 0xA5A5A5 and rdata_valid_o pulses once per frame at CS rise.

Source files
------------

// File: rtl/gpa_fhdo_spi_ctrl.sv
// SPI controller for the GPA-FHDO DAC board: one command word -> one or more DAC frames.
// Define GPA_FHDO_READBACK_EN to build the SDI capture path (rdata_o / rdata_valid_o).
module gpa_fhdo_spi_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int FRAME_BITS = 24,
  parameter int DIV_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DIV_W-1:0]      spi_clk_div_i,
  output logic                  fhd_clk_o,
  output logic                  fhd_sdo_o,
  output logic                  fhd_csn_o,
  input  logic                  fhd_sdi_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [FRAME_BITS-1:0] rdata_o,
  output logic                  rdata_valid_o
);

  localparam int               BIT_W    = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [DIV_W:0]   CNT_ONE  = (DIV_W+1)'(1);
  localparam logic [2:0]       LAST_CH  = 3'(NUM_CH - 1);
  localparam logic [3:0]       NUM_CH_W = 4'(NUM_CH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t                  state_q;
  logic [FRAME_BITS-1:0]   cmd_q;
  logic                    raw_q;
  logic                    bcast_q;
  logic [2:0]              ch_q;
  logic [DIV_W-1:0]        div_q;
  logic [DIV_W:0]          cnt_q;
  logic [BIT_W-1:0]        bit_q;
  logic                    low_q;
  logic [FRAME_BITS-1:0]   sr_q;
  logic                    init_done_q;
  logic                    sync_q;
  logic                    ready_q;
  logic                    err_q;
  logic                    sclk_q;
  logic                    sdo_q;
  logic                    csn_q;
  logic [FRAME_BITS-1:0]   frame_d;

  logic cmd_raw;
  logic cmd_bcast;
  logic cmd_bad;
  logic fall_stb;
  logic end_stb;

  assign cmd_raw   = data_i[25];
  assign cmd_bcast = data_i[24] && !cmd_raw;
  assign cmd_bad   = !cmd_raw && !data_i[24] && ({1'b0, data_i[18:16]} >= NUM_CH_W);

  // Until the DAC sync register has been written, every LOAD sends the sync frame first.
  always_comb begin
    frame_d = '0;
    if (!init_done_q) begin
      frame_d[17] = 1'b1;
    end else if (raw_q) begin
      frame_d = cmd_q;
    end else begin
      frame_d[19]    = 1'b1;
      frame_d[18:16] = ch_q;
      frame_d[15:0]  = cmd_q[15:0];
    end
  end

  assign fall_stb = (state_q == SHIFT) && (cnt_q == '0) && !low_q;
  assign end_stb  = (state_q == SHIFT) && (cnt_q == '0) && low_q && (bit_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      raw_q       <= 1'b0;
      bcast_q     <= 1'b0;
      ch_q        <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      low_q       <= 1'b0;
      sr_q        <= '0;
      init_done_q <= 1'b0;
      sync_q      <= 1'b0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      sclk_q      <= 1'b1;
      sdo_q       <= 1'b0;
      csn_q       <= 1'b1;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q <= LOAD;
              ready_q <= 1'b0;
              csn_q   <= 1'b0;
              cmd_q   <= data_i[FRAME_BITS-1:0];
              raw_q   <= cmd_raw;
              bcast_q <= cmd_bcast;
              ch_q    <= cmd_bcast ? 3'd0 : data_i[18:16];
              div_q   <= spi_clk_div_i;
              cnt_q   <= {1'b0, spi_clk_div_i};
            end
          end
        end
        // LOAD doubles as the CS-to-first-bit setup time of H cycles.
        LOAD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            state_q <= SHIFT;
            sdo_q   <= frame_d[FRAME_BITS-1];
            sr_q    <= {frame_d[FRAME_BITS-2:0], 1'b0};
            sync_q  <= !init_done_q;
            bit_q   <= LAST_BIT;
            low_q   <= 1'b0;
            cnt_q   <= {1'b0, div_q};
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (!low_q) begin
            sclk_q <= 1'b0;
            low_q  <= 1'b1;
            cnt_q  <= {1'b0, div_q};
          end else begin
            sclk_q <= 1'b1;
            low_q  <= 1'b0;
            if (bit_q == '0) begin
              csn_q   <= 1'b1;
              sdo_q   <= 1'b0;
              state_q <= GAP;
              cnt_q   <= {div_q, 1'b1};
            end else begin
              bit_q <= bit_q - BIT_ONE;
              sdo_q <= sr_q[FRAME_BITS-1];
              sr_q  <= {sr_q[FRAME_BITS-2:0], 1'b0};
              cnt_q <= {1'b0, div_q};
            end
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (sync_q) begin
            init_done_q <= 1'b1;
            sync_q      <= 1'b0;
            state_q     <= LOAD;
            csn_q       <= 1'b0;
            cnt_q       <= {1'b0, div_q};
          end else if (bcast_q && (ch_q < LAST_CH)) begin
            ch_q    <= ch_q + 3'd1;
            state_q <= LOAD;
            csn_q   <= 1'b0;
            cnt_q   <= {1'b0, div_q};
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o   = ready_q;
  assign busy_o    = !ready_q;
  assign err_o     = err_q;
  assign fhd_clk_o = sclk_q;
  assign fhd_sdo_o = sdo_q;
  assign fhd_csn_o = csn_q;

`ifdef GPA_FHDO_READBACK_EN
  logic [FRAME_BITS-1:0] rd_sr_q;
  logic [FRAME_BITS-1:0] rdata_q;
  logic                  rvalid_q;

  // SDI is sampled on the same clk edge that drives SCLK low; the last bit is in by CS rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sr_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (fall_stb) begin
        rd_sr_q <= {rd_sr_q[FRAME_BITS-2:0], fhd_sdi_i};
      end
      if (end_stb) begin
        rdata_q  <= rd_sr_q;
        rvalid_q <= 1'b1;
      end
    end
  end

  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;

  logic unused_bits;
  assign unused_bits = ^data_i[31:26];
`else
  assign rdata_o       = '0;
  assign rdata_valid_o = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{data_i[31:26], fhd_sdi_i, fall_stb, end_stb};
`endif

endmodule

// File: tb/tb_gpa_fhdo_spi_ctrl.sv
// Scoreboard bench for gpa_fhdo_spi_ctrl: expected frames queued at send, checked at CS rise.
// Readback checks follow GPA_FHDO_READBACK_EN in the same way as the design.
module tb_gpa_fhdo_spi_ctrl;
  localparam int FB  = 24;
  localparam int NCH = 4;
  localparam int DW  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   data;
  logic          valid;
  logic          ready;
  logic [DW-1:0] div_i;
  logic          sclk;
  logic          sdo;
  logic          csn;
  logic          sdi;
  logic          busy;
  logic          err;
  logic [FB-1:0] rdata;
  logic          rvalid;

  gpa_fhdo_spi_ctrl #(.NUM_CH(NCH), .FRAME_BITS(FB), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid), .ready_o(ready),
    .spi_clk_div_i(div_i), .fhd_clk_o(sclk), .fhd_sdo_o(sdo), .fhd_csn_o(csn),
    .fhd_sdi_i(sdi), .busy_o(busy), .err_o(err), .rdata_o(rdata), .rdata_valid_o(rvalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [FB-1:0] exp_q[$];
  int cur_h = 2;

  int mon_bits = 0;
  int low_cyc = 0;
  int high_cyc = 0;
  int frames_seen = 0;
  int rv_pulses = 0;
  logic mon_active = 1'b0;
  logic burst = 1'b0;
  logic prev_csn = 1'b1;
  logic prev_sclk = 1'b1;
  logic [FB-1:0] mon_word = '0;
  logic [FB-1:0] sdi_pat = 24'hA5A5A5;

  // Slave model: present pattern bit n before the n-th SCLK fall.
  assign sdi = (mon_active && mon_bits < FB) ? sdi_pat[FB-1-mon_bits] : 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      mon_bits   = 0;
      prev_csn   = 1'b1;
      prev_sclk  = 1'b1;
      high_cyc   = 0;
      burst      = 1'b0;
    end else begin
      if (rvalid) rv_pulses++;
      if (prev_csn && !csn) begin
        if (burst) begin
          checks++;
          if (high_cyc != 2 * cur_h) begin
            errors++;
            $display("FAIL gap: cs high %0d cycles, required %0d", high_cyc, 2 * cur_h);
          end
        end
        mon_active = 1'b1;
        mon_bits   = 0;
        low_cyc    = 0;
        mon_word   = '0;
      end
      if (!csn) low_cyc++;
      if (mon_active && !csn && prev_sclk && !sclk) begin
        mon_word = {mon_word[FB-2:0], sdo};
        mon_bits++;
      end
      if (mon_active && !prev_csn && csn) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame: got %06h, required none", mon_word);
        end else begin
          logic [FB-1:0] e;
          e = exp_q.pop_front();
          if (mon_word !== e) begin
            errors++;
            $display("FAIL frame: got %06h, required %06h", mon_word, e);
          end
        end
        checks++;
        if (mon_bits != FB) begin
          errors++;
          $display("FAIL bits: got %0d falls, required %0d", mon_bits, FB);
        end
        checks++;
        if (low_cyc != cur_h * (1 + 2 * FB)) begin
          errors++;
          $display("FAIL cs_low: got %0d cycles, required %0d", low_cyc, cur_h * (1 + 2 * FB));
        end
        checks++;
`ifdef GPA_FHDO_READBACK_EN
        if (rvalid !== 1'b1 || rdata !== sdi_pat) begin
          errors++;
          $display("FAIL readback: valid %b data %06h, required 1 %06h", rvalid, rdata, sdi_pat);
        end
`else
        if (rvalid !== 1'b0 || rdata !== '0) begin
          errors++;
          $display("FAIL readback: valid %b data %06h, required 0 000000", rvalid, rdata);
        end
`endif
        frames_seen++;
        mon_active = 1'b0;
        high_cyc   = 0;
        burst      = (exp_q.size() != 0);
      end
      if (csn) high_cyc++;
      prev_csn  = csn;
      prev_sclk = sclk;
    end
  end

  // Drives one command; returns at the negedge of the cycle after the accepting edge.
  task automatic send_cmd(input logic [31:0] d, input logic [DW-1:0] dv);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_send: got %b, required 1", ready);
    end
    data  = d;
    div_i = dv;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle(input int start, output int n);
    n = start;
    while (ready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: ready still %b after %0d cycles", ready, n);
    end
  endtask

  task automatic check_cmd_len(input string name, input int n, input int frames);
    int req;
    req = frames * cur_h * (3 + 2 * FB) + 1;
    checks++;
    if (n != req) begin
      errors++;
      $display("FAIL %s_len: ready after %0d cycles, required %0d", name, n, req);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d frames missing, required 0", name, exp_q.size());
    end
    $display("cmd %s: %0d frames, %0d cycles", name, frames, n);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    div_i = 6'd1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, busy, sclk, csn, sdo, err, rvalid} !== 7'b1011000 || rdata !== '0) begin
      errors++;
      $display("FAIL reset: rdy %b busy %b sclk %b csn %b sdo %b err %b rv %b rd %06h, required 1 0 1 1 0 0 0 0",
               ready, busy, sclk, csn, sdo, err, rvalid, rdata);
    end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_first_cmd();
    int n;
    exp_q.push_back(24'h020000);
    exp_q.push_back(24'h09ABCD);
    send_cmd(32'h0001_ABCD, 6'd1);
    checks++;
    if (csn !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency: csn %b busy %b one cycle after accept, required 0 1", csn, busy);
    end
    wait_idle(1, n);
    check_cmd_len("first", n, 2);
  endtask

  task automatic test_second_cmd();
    int n;
    exp_q.push_back(24'h081234);
    send_cmd(32'h0000_1234, 6'd1);
    wait_idle(1, n);
    check_cmd_len("second", n, 1);
  endtask

  task automatic test_broadcast();
    int n;
    exp_q.push_back(24'h088000);
    exp_q.push_back(24'h098000);
    exp_q.push_back(24'h0A8000);
    exp_q.push_back(24'h0B8000);
    send_cmd(32'h0100_8000, 6'd1);
    div_i = 6'd5;
    wait_idle(1, n);
    check_cmd_len("broadcast", n, 4);
    div_i = 6'd1;
  endtask

  task automatic test_raw();
    int n;
    exp_q.push_back(24'h071234);
    send_cmd(32'h0307_1234, 6'd1);
    wait_idle(1, n);
    check_cmd_len("raw", n, 1);
  endtask

  task automatic test_err_and_busy();
    int n;
    int f0;
    int idle_bad;
    f0 = frames_seen;
    send_cmd(32'h0005_1111, 6'd1);
    checks++;
    if (err !== 1'b1 || ready !== 1'b1 || csn !== 1'b1 || sclk !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse: err %b rdy %b csn %b sclk %b, required 1 1 1 1", err, ready, csn, sclk);
    end
    idle_bad = 0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_width: err %b second cycle, required 0", err);
    end
    for (int i = 0; i < 20; i++) begin
      if (csn !== 1'b1 || sclk !== 1'b1 || ready !== 1'b1) idle_bad++;
      @(negedge clk);
    end
    checks++;
    if (idle_bad != 0 || frames_seen != f0) begin
      errors++;
      $display("FAIL err_idle: %0d busy cycles, %0d frames, required 0 0", idle_bad, frames_seen - f0);
    end
    $display("cmd err: channel 5 rejected");
    exp_q.push_back(24'h0A2222);
    send_cmd(32'h0002_2222, 6'd1);
    data  = 32'h0001_3333;
    valid = 1'b1;
    repeat (50) @(negedge clk);
    valid = 1'b0;
    wait_idle(51, n);
    check_cmd_len("busy_ignore", n, 1);
    checks++;
    if (frames_seen != f0 + 1) begin
      errors++;
      $display("FAIL busy_count: %0d frames, required %0d", frames_seen - f0, 1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int k;
    exp_q.push_back(24'h0B4444);
    send_cmd(32'h0003_4444, 6'd1);
    k = 0;
    while (mon_bits < 10 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (csn !== 1'b1 || sclk !== 1'b1 || sdo !== 1'b0 || ready !== 1'b1 || k >= 2000) begin
      errors++;
      $display("FAIL reset_mid: csn %b sclk %b sdo %b rdy %b, required 1 1 0 1", csn, sclk, sdo, ready);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    $display("cmd reset_mid: aborted at bit %0d", mon_bits);
    exp_q.push_back(24'h020000);
    exp_q.push_back(24'h095555);
    send_cmd(32'h0001_5555, 6'd1);
    wait_idle(1, n);
    check_cmd_len("after_reset", n, 2);
  endtask

  initial begin
    int req_rv;
    test_reset();
    test_first_cmd();
    test_second_cmd();
    test_broadcast();
    test_raw();
    test_err_and_busy();
    test_reset_mid();
    repeat (5) @(negedge clk);
`ifdef GPA_FHDO_READBACK_EN
    req_rv = frames_seen;
`else
    req_rv = 0;
`endif
    checks++;
    if (rv_pulses != req_rv) begin
      errors++;
      $display("FAIL rvalid_count: %0d pulses, required %0d", rv_pulses, req_rv);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
